// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encoding and controller state enum.
package muldiv_iter_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the datapath: shift-add for multiply,
// trial-subtract/shift (restoring) for divide, on unsigned magnitudes.
module muldiv_step
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             op_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem;
   logic [WIDTH:0] diff;

   always_comb begin
      sum  = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
      rem  = {acc_i, lo_i[WIDTH-1]};
      diff = rem - {1'b0, b_i};
      if (op_i == OP_MUL) begin
         acc_o = sum[WIDTH:1];
         lo_o  = {sum[0], lo_i[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         // partial remainder stays below the divisor, so WIDTH bits suffice
         acc_o = diff[WIDTH-1:0];
         lo_o  = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
         acc_o = rem[WIDTH-1:0];
         lo_o  = {lo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one result bit per clock, signed mode on
// magnitudes with sign fix-up on the final edge, divide-by-zero short cut.
//
// state   | meaning
// IDLE    | waiting for start_i
// COMPUTE | iterating, cnt_q = iteration performed on the next edge
// DONE    | results valid for one cycle, start_i accepted back-to-back
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             op_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] operand1_i,
   input  logic [WIDTH-1:0] operand2_i,
   output logic [WIDTH-1:0] result1_o,
   output logic [WIDTH-1:0] result2_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       acc_q, acc_d;
   logic [WIDTH-1:0]       lo_q, lo_d;
   logic [WIDTH-1:0]       opb_q, opb_d;
   logic                   op_q, op_d;
   logic                   neg_res_q, neg_res_d;
   logic                   neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]       result1_q, result1_d;
   logic [WIDTH-1:0]       result2_q, result2_d;
   logic                   div_zero_q, div_zero_d;

   logic                   accept;
   logic                   s1, s2;
   logic [WIDTH-1:0]       mag1, mag2;
   logic [WIDTH-1:0]       step_acc, step_lo;
   logic [2*WIDTH-1:0]     prod;
   logic [WIDTH-1:0]       quo, rem;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op_i  (op_q),
      .acc_i (acc_q),
      .lo_i  (lo_q),
      .b_i   (opb_q),
      .acc_o (step_acc),
      .lo_o  (step_lo)
   );

   assign accept     = start_i & (state_q != COMPUTE);
   assign busy_o     = (state_q == COMPUTE) | accept;
   assign done_o     = (state_q == DONE);
   assign result1_o  = result1_q;
   assign result2_o  = result2_q;
   assign div_zero_o = div_zero_q;

   assign s1   = signed_i & operand1_i[WIDTH-1];
   assign s2   = signed_i & operand2_i[WIDTH-1];
   assign mag1 = s1 ? -operand1_i : operand1_i;
   assign mag2 = s2 ? -operand2_i : operand2_i;

   assign prod = neg_res_q ? -{step_acc, step_lo} : {step_acc, step_lo};
   assign quo  = neg_res_q ? -step_lo : step_lo;
   assign rem  = neg_rem_q ? -step_acc : step_acc;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      lo_d       = lo_q;
      opb_d      = opb_q;
      op_d       = op_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      result1_d  = result1_q;
      result2_d  = result2_q;
      div_zero_d = div_zero_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_i) begin
               div_zero_d = 1'b0;
               cnt_d      = '0;
               acc_d      = '0;
               op_d       = op_i;
               neg_res_d  = s1 ^ s2;
               neg_rem_d  = s1;
               opb_d      = (op_i == OP_MUL) ? mag1 : mag2;
               lo_d       = (op_i == OP_MUL) ? mag2 : mag1;
               if (op_i == OP_DIV && operand2_i == '0) begin
                  state_d    = DONE;
                  result1_d  = '1;
                  result2_d  = operand1_i;
                  div_zero_d = 1'b1;
               end else begin
                  state_d = COMPUTE;
               end
            end
         end
         COMPUTE: begin
            acc_d = step_acc;
            lo_d  = step_lo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               if (op_q == OP_MUL) begin
                  result1_d = prod[WIDTH-1:0];
                  result2_d = prod[2*WIDTH-1:WIDTH];
               end else begin
                  result1_d = quo;
                  result2_d = rem;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         opb_q      <= '0;
         op_q       <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         result1_q  <= '0;
         result2_q  <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         lo_q       <= lo_d;
         opb_q      <= opb_d;
         op_q       <= op_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         result1_q  <= result1_d;
         result2_q  <= result2_d;
         div_zero_q <= div_zero_d;
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter at WIDTH 8, 16 and 32: directed cases followed by
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_iter;
   import muldiv_iter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_v [3];
   logic        op_v    [3];
   logic        sg_v    [3];
   logic [63:0] a_v     [3];
   logic [63:0] b_v     [3];
   logic        done_w  [3];
   logic        busy_w  [3];
   logic        dz_w    [3];
   logic [63:0] r1_w    [3];
   logic [63:0] r2_w    [3];
   logic [7:0]  r1_8,  r2_8;
   logic [15:0] r1_16, r2_16;
   logic [31:0] r1_32, r2_32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_iter #(.WIDTH(8)) u_dut8 (
      .clk_i(clk), .rst_n(rst_n), .start_i(start_v[0]), .op_i(op_v[0]), .signed_i(sg_v[0]),
      .operand1_i(a_v[0][7:0]), .operand2_i(b_v[0][7:0]), .result1_o(r1_8), .result2_o(r2_8),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .div_zero_o(dz_w[0]));

   muldiv_iter #(.WIDTH(16)) u_dut16 (
      .clk_i(clk), .rst_n(rst_n), .start_i(start_v[1]), .op_i(op_v[1]), .signed_i(sg_v[1]),
      .operand1_i(a_v[1][15:0]), .operand2_i(b_v[1][15:0]), .result1_o(r1_16), .result2_o(r2_16),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .div_zero_o(dz_w[1]));

   muldiv_iter #(.WIDTH(32)) u_dut32 (
      .clk_i(clk), .rst_n(rst_n), .start_i(start_v[2]), .op_i(op_v[2]), .signed_i(sg_v[2]),
      .operand1_i(a_v[2][31:0]), .operand2_i(b_v[2][31:0]), .result1_o(r1_32), .result2_o(r2_32),
      .busy_o(busy_w[2]), .done_o(done_w[2]), .div_zero_o(dz_w[2]));

   assign r1_w[0] = 64'(r1_8);
   assign r2_w[0] = 64'(r2_8);
   assign r1_w[1] = 64'(r1_16);
   assign r2_w[1] = 64'(r2_16);
   assign r1_w[2] = 64'(r1_32);
   assign r2_w[2] = 64'(r2_32);

   function automatic int wof(input int d);
      return (d == 0) ? 8 : (d == 1) ? 16 : 32;
   endfunction

   // Reference: plain signed/unsigned arithmetic on sign- or zero-extended operands.
   function automatic void model(input int w, input logic op, input logic sg,
                                 input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r1, output logic [63:0] r2,
                                 output logic dz);
      logic [63:0] mask;
      logic [63:0] p;
      longint sa, sb, q, r;
      mask = (64'd1 << w) - 64'd1;
      sa = sg ? (longint'(a << (64 - w)) >>> (64 - w)) : longint'(a);
      sb = sg ? (longint'(b << (64 - w)) >>> (64 - w)) : longint'(b);
      dz = 1'b0;
      if (op == OP_MUL) begin
         p  = sa * sb;
         r1 = p & mask;
         r2 = (p >> w) & mask;
      end else if (b == 64'd0) begin
         r1 = mask;
         r2 = a;
         dz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         r1 = q & mask;
         r2 = r & mask;
      end
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input int d, input logic op, input logic sg,
                        input logic [63:0] a, input logic [63:0] b);
      op_v[d]    = op;
      sg_v[d]    = sg;
      a_v[d]     = a;
      b_v[d]     = b;
      start_v[d] = 1'b1;
      #1;
      check("busy_cycle0", 64'(busy_w[d]), 64'd1);
   endtask

   task automatic wait_done(input int d, input int lat, input bit hold,
                            input logic [63:0] e1, input logic [63:0] e2,
                            input logic edz, input string tag);
      int n;
      bit seen;
      bit busy_ok;
      seen    = 1'b0;
      busy_ok = 1'b1;
      for (n = 1; n <= 80; n++) begin
         @(posedge clk);
         #1;
         if (!hold) start_v[d] = 1'b0;
         if (done_w[d]) begin
            seen = 1'b1;
            break;
         end
         if (!busy_w[d]) busy_ok = 1'b0;
         if (hold) begin
            a_v[d]  = {$urandom, $urandom};
            b_v[d]  = {$urandom, $urandom};
            op_v[d] = 1'($urandom_range(0, 1));
            sg_v[d] = 1'($urandom_range(0, 1));
         end
      end
      start_v[d] = 1'b0;
      #1;
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy_w[d]), 64'd0);
      check({tag, "_result1"}, r1_w[d], e1);
      check({tag, "_result2"}, r2_w[d], e2);
      check({tag, "_divzero"}, 64'(dz_w[d]), 64'(edz));
   endtask

   initial begin
      logic [63:0] mask, a, b, e1, e2;
      logic        op, sg, edz;
      bit          done_after;
      int          w, sel;
      int          nops [3];

      nops = '{1200, 700, 500};
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_v[d] = 1'b0; op_v[d] = 1'b0; sg_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0;
      end
      #12;
      check("rst_busy", 64'(busy_w[2]), 64'd0);
      check("rst_done", 64'(done_w[2]), 64'd0);
      check("rst_r1", r1_w[2], 64'd0);
      check("rst_r2", r2_w[2], 64'd0);
      check("rst_dz", 64'(dz_w[2]), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("idle_busy_eq_start", 64'(busy_w[2]), 64'd0);

      issue(2, OP_MUL, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_done(2, 33, 1'b0, 64'h0000_0001, 64'hFFFF_FFFE, 1'b0, "mul_max");
      issue(2, OP_DIV, 1'b1, 64'hFFFF_FFF9, 64'd2);
      wait_done(2, 33, 1'b0, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 1'b0, "sdiv_m7_2");
      issue(2, OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
      wait_done(2, 33, 1'b0, 64'h8000_0000, 64'd0, 1'b0, "sdiv_min_m1");
      issue(2, OP_DIV, 1'b0, 64'd1234, 64'd0);
      wait_done(2, 1, 1'b0, 64'hFFFF_FFFF, 64'd1234, 1'b1, "div_zero");
      issue(2, OP_MUL, 1'b0, 64'd3, 64'd5);
      wait_done(2, 33, 1'b0, 64'd15, 64'd0, 1'b0, "mul_after_dz");

      issue(0, OP_MUL, 1'b1, 64'hFD, 64'h05);
      wait_done(0, 9, 1'b1, 64'hF1, 64'hFF, 1'b0, "smul8_hold");
      issue(0, OP_MUL, 1'b0, 64'd7, 64'd9);
      wait_done(0, 9, 1'b0, 64'd63, 64'd0, 1'b0, "b2b_mul8");

      issue(2, OP_MUL, 1'b0, 64'h1234_5678, 64'h9ABC_DEF1);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         start_v[2] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy_w[2]), 64'd0);
      check("abort_done", 64'(done_w[2]), 64'd0);
      check("abort_r1", r1_w[2], 64'd0);
      check("abort_r2", r2_w[2], 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_after = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done_w[2]) done_after = 1'b1;
      end
      check("abort_no_done", 64'(done_after), 64'd0);
      issue(2, OP_MUL, 1'b0, 64'd2, 64'd3);
      wait_done(2, 33, 1'b0, 64'd6, 64'd0, 1'b0, "mul_after_abort");

      for (int d = 0; d < 3; d++) begin
         w = wof(d);
         mask = (64'd1 << w) - 64'd1;
         for (int i = 0; i < nops[d]; i++) begin
            op  = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            a   = {$urandom, $urandom} & mask;
            b   = {$urandom, $urandom} & mask;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 64'd0;
            else if (sel == 1) begin
               a = 64'd1 << (w - 1);
               b = mask;
            end else if (sel == 2) b = 64'($urandom_range(1, 3));
            model(w, op, sg, a, b, e1, e2, edz);
            issue(d, op, sg, a, b);
            wait_done(d, edz ? 1 : w + 1, 1'b0, e1, e2, edz, "rnd");
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clk);
               #1;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
